// File: rtl/font_glyph_engine.sv
// Three-stage text-mode glyph renderer: tile code + pixel position -> RGB.
// Optional blink attribute support is built when FONT_GLYPH_BLINK_EN is defined.
module font_glyph_engine #(
  parameter int CODE_W       = 4,
  parameter int SCALE_LOG2   = 0,
  parameter int COLOR_W      = 12,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_tick,
  input  logic               video_on,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  input  logic [CODE_W-1:0]  glyph_code,
  input  logic               blink,
  input  logic               frame_start,
  input  logic [COLOR_W-1:0] fg_color,
  input  logic [COLOR_W-1:0] bg_color,
  output logic [COLOR_W-1:0] rgb,
  output logic               rgb_valid
);

  // Each glyph packs rows 0..15 from MSB to LSB, one byte per row.
  function automatic logic [127:0] glyph(input logic [5:0] c);
    case (c)
      6'd0:    glyph = 128'h003C_6666_666E_7666_6666_6666_663C_0000;
      6'd1:    glyph = 128'h0010_3050_1010_1010_1010_1010_107C_0000;
      6'd2:    glyph = 128'h003C_6606_060C_1830_6060_6066_7E7E_0000;
      6'd3:    glyph = 128'h003C_6606_061C_0606_0606_0666_663C_0000;
      6'd4:    glyph = 128'h000C_1C3C_6CCC_CCFE_0C0C_0C0C_0C1E_0000;
      6'd5:    glyph = 128'h007E_6060_607C_0606_0606_0666_663C_0000;
      6'd6:    glyph = 128'h001C_3060_607C_6666_6666_6666_663C_0000;
      6'd7:    glyph = 128'h007E_6606_060C_0C18_1818_1818_1818_0000;
      6'd8:    glyph = 128'h003C_6666_663C_6666_6666_6666_663C_0000;
      6'd9:    glyph = 128'h003C_6666_6666_3E06_0606_060C_3870_0000;
      6'd10:   glyph = 128'h0000_0000_0030_0000_0000_0030_0000_0000;
      6'd11:   glyph = 128'h0018_3C3C_3C3C_7E7E_FFFF_0018_1800_0000;
      default: glyph = '0;
    endcase
  endfunction

  logic [9:0]         x_s, y_s;
  logic [CODE_W-1:0]  s1_code_q, s1_code_d;
  logic [3:0]         s1_row_q, s1_row_d;
  logic [2:0]         s1_col_q, s1_col_d;
  logic               s1_vid_q, s1_vid_d;
  logic [COLOR_W-1:0] s1_fg_q, s1_fg_d, s1_bg_q, s1_bg_d;
  logic [7:0]         s2_bits_q, s2_bits_d;
  logic [2:0]         s2_col_q, s2_col_d;
  logic               s2_vid_q, s2_vid_d;
  logic [COLOR_W-1:0] s2_fg_q, s2_fg_d, s2_bg_q, s2_bg_d;
  logic [COLOR_W-1:0] rgb_q, rgb_d;
  logic               rgb_valid_q, rgb_valid_d;
  logic [127:0]       rom_glyph;
  logic [6:0]         rom_sh;
  logic               pix_on;
  logic               suppress;
  logic               unused_xy;

  assign x_s = pixel_x >> SCALE_LOG2;
  assign y_s = pixel_y >> SCALE_LOG2;
  assign unused_xy = ^{x_s[9:3], y_s[9:4]};

  always_comb begin
    s1_code_d   = s1_code_q;
    s1_row_d    = s1_row_q;
    s1_col_d    = s1_col_q;
    s1_vid_d    = s1_vid_q;
    s1_fg_d     = s1_fg_q;
    s1_bg_d     = s1_bg_q;
    s2_bits_d   = s2_bits_q;
    s2_col_d    = s2_col_q;
    s2_vid_d    = s2_vid_q;
    s2_fg_d     = s2_fg_q;
    s2_bg_d     = s2_bg_q;
    rgb_d       = rgb_q;
    rgb_valid_d = rgb_valid_q;
    rom_glyph   = glyph(6'(s1_code_q));
    rom_sh      = {4'd15 - s1_row_q, 3'b000};
    pix_on      = s2_bits_q[3'd7 - s2_col_q] & ~suppress;
    if (pix_tick) begin
      s1_code_d   = glyph_code;
      s1_row_d    = y_s[3:0];
      s1_col_d    = x_s[2:0];
      s1_vid_d    = video_on;
      s1_fg_d     = fg_color;
      s1_bg_d     = bg_color;
      s2_bits_d   = rom_glyph[rom_sh +: 8];
      s2_col_d    = s1_col_q;
      s2_vid_d    = s1_vid_q;
      s2_fg_d     = s1_fg_q;
      s2_bg_d     = s1_bg_q;
      rgb_d       = s2_vid_q ? (pix_on ? s2_fg_q : s2_bg_q) : '0;
      rgb_valid_d = s2_vid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_code_q   <= '0;
      s1_row_q    <= '0;
      s1_col_q    <= '0;
      s1_vid_q    <= 1'b0;
      s1_fg_q     <= '0;
      s1_bg_q     <= '0;
      s2_bits_q   <= '0;
      s2_col_q    <= '0;
      s2_vid_q    <= 1'b0;
      s2_fg_q     <= '0;
      s2_bg_q     <= '0;
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
    end else begin
      s1_code_q   <= s1_code_d;
      s1_row_q    <= s1_row_d;
      s1_col_q    <= s1_col_d;
      s1_vid_q    <= s1_vid_d;
      s1_fg_q     <= s1_fg_d;
      s1_bg_q     <= s1_bg_d;
      s2_bits_q   <= s2_bits_d;
      s2_col_q    <= s2_col_d;
      s2_vid_q    <= s2_vid_d;
      s2_fg_q     <= s2_fg_d;
      s2_bg_q     <= s2_bg_d;
      rgb_q       <= rgb_d;
      rgb_valid_q <= rgb_valid_d;
    end
  end

`ifdef FONT_GLYPH_BLINK_EN
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic             s1_blink_q, s1_blink_d;
  logic             s2_blink_q, s2_blink_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  always_comb begin
    s1_blink_d = s1_blink_q;
    s2_blink_d = s2_blink_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    if (pix_tick) begin
      s1_blink_d = blink;
      s2_blink_d = s1_blink_q;
    end
    if (frame_start) begin
      if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_blink_q <= 1'b0;
      s2_blink_q <= 1'b0;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
    end else begin
      s1_blink_q <= s1_blink_d;
      s2_blink_q <= s2_blink_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
    end
  end

  assign suppress = s2_blink_q & phase_q;
`else
  logic unused_blink;
  assign unused_blink = ^{blink, frame_start};
  assign suppress = 1'b0;
`endif

  assign rgb       = rgb_q;
  assign rgb_valid = rgb_valid_q;

endmodule
